// File: rtl/pacote_rv.sv
// rtl/pacote_rv.sv - shared register-file constants and writeback requester indices
package pacote_rv;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam int REQ_ULA  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_MUL  = 2;

endpackage

// File: rtl/arbitro_round_robin.sv
// rtl/arbitro_round_robin.sv - round-robin one-hot arbiter owning the rotation pointer
module arbitro_round_robin #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] requisicao,
    input  logic               aceita,
    output logic [NUM_REQ-1:0] concessao
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] indice_sel;
    logic             achou;
    int               idx;

    // Search for the first valid requester starting at ptr, wrapping around.
    always_comb begin
        concessao  = '0;
        indice_sel = '0;
        achou      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!achou && requisicao[idx]) begin
                achou          = 1'b1;
                concessao[idx] = 1'b1;
                indice_sel     = PTR_W'(idx);
            end
        end
        // No grant may leave the block while it is being reset.
        if (reset) begin
            concessao = '0;
        end
    end

    // Pointer moves just past the winner after a transfer, otherwise holds.
    always_comb begin
        ptr_d = ptr_q;
        if (aceita) begin
            if (indice_sel == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = indice_sel + PTR_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/controle_escrita_registradores.sv
// rtl/controle_escrita_registradores.sv - register-file write-port arbiter, output stage and pending-write scoreboard
module controle_escrita_registradores
    import pacote_rv::*;
#(
    parameter int NUM_REQ = 3,
    parameter int LARGURA = DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valida,
    output logic [NUM_REQ-1:0]          req_pronta,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_endereco,
    input  logic [NUM_REQ*LARGURA-1:0]  req_dado,
    input  logic                        reserva_valida,
    input  logic [ADDR_W-1:0]           reserva_endereco,
    output logic                        reserva_pronta,
    input  logic [ADDR_W-1:0]           EnderecoLeitura1,
    input  logic [ADDR_W-1:0]           EnderecoLeitura2,
    output logic                        pendente1,
    output logic                        pendente2,
    output logic                        EscreveRegistrador,
    output logic [ADDR_W-1:0]           EnderecoEscrita,
    output logic [LARGURA-1:0]          DadoParaEscrita
);

    logic                transferencia;
    logic [ADDR_W-1:0]   endereco_sel;
    logic [LARGURA-1:0]  dado_sel;

    logic                escreve_q;
    logic                escreve_d;
    logic [ADDR_W-1:0]   endereco_q;
    logic [ADDR_W-1:0]   endereco_d;
    logic [LARGURA-1:0]  dado_q;
    logic [LARGURA-1:0]  dado_d;
    logic [NUM_REGS-1:0] ocupado_q;
    logic [NUM_REGS-1:0] ocupado_d;

    arbitro_round_robin #(
        .NUM_REQ    (NUM_REQ)
    ) u_arbitro (
        .clk        (clk),
        .reset      (reset),
        .requisicao (req_valida),
        .aceita     (transferencia),
        .concessao  (req_pronta)
    );

    assign transferencia = |(req_valida & req_pronta);

    // Route the granted requester's address and data; grant is one-hot so OR-merging is safe.
    always_comb begin
        endereco_sel = '0;
        dado_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pronta[i]) begin
                endereco_sel = endereco_sel | req_endereco[ADDR_W*i +: ADDR_W];
                dado_sel     = dado_sel | req_dado[LARGURA*i +: LARGURA];
            end
        end
    end

    // Output stage: load on a transfer; x0 is consumed without raising the enable.
    always_comb begin
        escreve_d  = 1'b0;
        endereco_d = endereco_q;
        dado_d     = dado_q;
        if (transferencia) begin
            escreve_d  = (endereco_sel != '0);
            endereco_d = endereco_sel;
            dado_d     = dado_sel;
        end
    end

    // Scoreboard: clear on the committing edge, then apply a legal reservation so set wins.
    always_comb begin
        ocupado_d = ocupado_q;
        if (escreve_q) begin
            ocupado_d[endereco_q] = 1'b0;
        end
        if (reserva_valida && reserva_pronta && (reserva_endereco != '0)) begin
            ocupado_d[reserva_endereco] = 1'b1;
        end
        ocupado_d[0] = 1'b0;
    end

    // Output-stage and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            escreve_q  <= 1'b0;
            endereco_q <= '0;
            dado_q     <= '0;
            ocupado_q  <= '0;
        end else begin
            escreve_q  <= escreve_d;
            endereco_q <= endereco_d;
            dado_q     <= dado_d;
            ocupado_q  <= ocupado_d;
        end
    end

    // Bit 0 of the scoreboard is never set, so x0 always reads as free and not pending.
    assign reserva_pronta     = ~ocupado_q[reserva_endereco];
    assign pendente1          = ocupado_q[EnderecoLeitura1];
    assign pendente2          = ocupado_q[EnderecoLeitura2];

    assign EscreveRegistrador = escreve_q;
    assign EnderecoEscrita    = endereco_q;
    assign DadoParaEscrita    = dado_q;

endmodule

// File: tb/tb_controle_escrita_registradores.sv
// tb/tb_controle_escrita_registradores.sv - randomized self-checking bench against a behavioural model
module tb_controle_escrita_registradores;
    import pacote_rv::*;

    localparam int N = 3;
    localparam int L = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valida;
    logic [N-1:0]      req_pronta;
    logic [N*5-1:0]    req_endereco;
    logic [N*L-1:0]    req_dado;
    logic              reserva_valida;
    logic [4:0]        reserva_endereco;
    logic              reserva_pronta;
    logic [4:0]        EnderecoLeitura1;
    logic [4:0]        EnderecoLeitura2;
    logic              pendente1;
    logic              pendente2;
    logic              EscreveRegistrador;
    logic [4:0]        EnderecoEscrita;
    logic [L-1:0]      DadoParaEscrita;

    controle_escrita_registradores #(
        .NUM_REQ            (N),
        .LARGURA            (L)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valida         (req_valida),
        .req_pronta         (req_pronta),
        .req_endereco       (req_endereco),
        .req_dado           (req_dado),
        .reserva_valida     (reserva_valida),
        .reserva_endereco   (reserva_endereco),
        .reserva_pronta     (reserva_pronta),
        .EnderecoLeitura1   (EnderecoLeitura1),
        .EnderecoLeitura2   (EnderecoLeitura2),
        .pendente1          (pendente1),
        .pendente2          (pendente2),
        .EscreveRegistrador (EscreveRegistrador),
        .EnderecoEscrita    (EnderecoEscrita),
        .DadoParaEscrita    (DadoParaEscrita)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester-side state: each requester holds its request until granted.
    logic        r_val  [N];
    logic [4:0]  r_addr [N];
    logic [31:0] r_data [N];

    // Behavioural model of the architectural state.
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    logic [N-1:0] last_grant;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic dirige();
        for (int i = 0; i < N; i++) begin
            req_valida[i]         = r_val[i];
            req_endereco[5*i +: 5] = r_addr[i];
            req_dado[L*i +: L]    = r_data[i];
        end
    endtask

    // One clock cycle: called at the negedge with stimulus set; checks, then advances the model.
    task automatic ciclo();
        logic [N-1:0] eg;
        int gi;
        bit          n_we;
        bit [4:0]    n_addr;
        bit [31:0]   n_data;
        bit [31:0]   n_busy;
        int          n_ptr;
        dirige();
        #1;
        eg = '0;
        gi = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (gi < 0 && r_val[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        last_grant = req_pronta;
        verifica("req_pronta", 32'(req_pronta), 32'(eg));
        verifica("reserva_pronta", 32'(reserva_pronta),
                 32'((reserva_endereco == 0) ? 1'b1 : !m_busy[reserva_endereco]));
        verifica("pendente1", 32'(pendente1),
                 32'((EnderecoLeitura1 == 0) ? 1'b0 : m_busy[EnderecoLeitura1]));
        verifica("pendente2", 32'(pendente2),
                 32'((EnderecoLeitura2 == 0) ? 1'b0 : m_busy[EnderecoLeitura2]));
        verifica("escreve", 32'(EscreveRegistrador), 32'(m_we));
        verifica("end_escrita", 32'(EnderecoEscrita), 32'(m_addr));
        verifica("dado_escrita", DadoParaEscrita, m_data);

        n_busy = m_busy;
        n_ptr  = m_ptr;
        n_we   = 1'b0;
        n_addr = m_addr;
        n_data = m_data;
        if (gi >= 0) begin
            n_we   = (r_addr[gi] != 0);
            n_addr = r_addr[gi];
            n_data = r_data[gi];
            n_ptr  = (gi + 1) % N;
        end
        if (m_we) n_busy[m_addr] = 1'b0;
        if (reserva_valida && reserva_endereco != 0 && !m_busy[reserva_endereco])
            n_busy[reserva_endereco] = 1'b1;
        if (reset) begin
            n_busy = '0; n_ptr = 0; n_we = 0; n_addr = '0; n_data = '0;
        end

        @(posedge clk);
        m_busy = n_busy; m_ptr = n_ptr; m_we = n_we; m_addr = n_addr; m_data = n_data;
        if (gi >= 0) r_val[gi] = 1'b0;
        @(negedge clk);
    endtask

    task automatic quieto();
        reserva_valida   = 1'b0;
        reserva_endereco = '0;
        EnderecoLeitura1 = '0;
        EnderecoLeitura2 = '0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_val[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
        end
        quieto();
        dirige();
        repeat (3) @(posedge clk);
        m_ptr = 0; m_busy = '0; m_we = 0; m_addr = '0; m_data = '0;
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        ciclo();
        verifica("idle_pronta", 32'(last_grant), 32'd0);
        verifica("idle_reserva_pronta", 32'(reserva_pronta), 32'd1);
        verifica("idle_escreve", 32'(EscreveRegistrador), 32'd0);

        // Single write from the ALU.
        r_val[REQ_ULA] = 1'b1; r_addr[REQ_ULA] = 5'd5; r_data[REQ_ULA] = 32'hDEADBEEF;
        ciclo();
        verifica("single_grant", 32'(last_grant), 32'd1);
        verifica("single_we", 32'(EscreveRegistrador), 32'd1);
        verifica("single_addr", 32'(EnderecoEscrita), 32'd5);
        verifica("single_data", DadoParaEscrita, 32'hDEADBEEF);
        ciclo();
        verifica("single_we_off", 32'(EscreveRegistrador), 32'd0);

        // Round-robin from a fresh pointer with all three continuously valid.
        reset = 1'b1; ciclo(); reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_val[i]) begin
                    r_val[i] = 1'b1; r_addr[i] = 5'(i + 1); r_data[i] = 32'(100 * c + i);
                end
            end
            ciclo();
            verifica("rr_grant", 32'(last_grant), 32'(1 << (c % 3)));
            verifica("rr_we", 32'(EscreveRegistrador), 32'd1);
            verifica("rr_addr", 32'(EnderecoEscrita), 32'((c % 3) + 1));
        end
        for (int i = 0; i < N; i++) r_val[i] = 1'b0;
        ciclo();

        // Hazard: reserve x7, observe pending, then MEM writes x7.
        reserva_valida = 1'b1; reserva_endereco = 5'd7;
        ciclo();
        reserva_valida = 1'b0; EnderecoLeitura1 = 5'd7;
        #1;
        verifica("haz_pend", 32'(pendente1), 32'd1);
        verifica("haz_res_pronta", 32'(reserva_pronta), 32'd0);
        r_val[REQ_MEM] = 1'b1; r_addr[REQ_MEM] = 5'd7; r_data[REQ_MEM] = 32'h7777;
        ciclo();
        verifica("haz_we", 32'(EscreveRegistrador), 32'd1);
        verifica("haz_pend_write", 32'(pendente1), 32'd1);
        ciclo();
        verifica("haz_pend_clear", 32'(pendente1), 32'd0);
        quieto();

        // x0 request accepted with no write enable; x0 reservation ignored.
        r_val[REQ_MUL] = 1'b1; r_addr[REQ_MUL] = 5'd0; r_data[REQ_MUL] = 32'h1234;
        reserva_valida = 1'b1; reserva_endereco = 5'd0;
        ciclo();
        verifica("x0_grant", 32'(last_grant), 32'd4);
        verifica("x0_we", 32'(EscreveRegistrador), 32'd0);
        reserva_valida = 1'b0;
        #1;
        verifica("x0_res_pronta", 32'(reserva_pronta), 32'd1);
        verifica("x0_pend", 32'(pendente1), 32'd0);

        // Reservation of x9 on the edge that commits a write to x9.
        r_val[REQ_ULA] = 1'b1; r_addr[REQ_ULA] = 5'd9; r_data[REQ_ULA] = 32'h99;
        ciclo();
        reserva_valida = 1'b1; reserva_endereco = 5'd9;
        ciclo();
        quieto(); EnderecoLeitura2 = 5'd9;
        #1;
        verifica("x9_busy", 32'(pendente2), 32'd1);
        r_val[REQ_ULA] = 1'b1; r_addr[REQ_ULA] = 5'd9; r_data[REQ_ULA] = 32'h98;
        ciclo(); ciclo(); ciclo();

        // Reset the cycle after an acceptance.
        r_val[REQ_MEM] = 1'b1; r_addr[REQ_MEM] = 5'd5; r_data[REQ_MEM] = 32'h55;
        reserva_valida = 1'b1; reserva_endereco = 5'd12;
        ciclo();
        quieto(); EnderecoLeitura1 = 5'd12;
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        #1;
        verifica("rst_we", 32'(EscreveRegistrador), 32'd0);
        verifica("rst_pend", 32'(pendente1), 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_val[i] && ($urandom_range(0, 1) == 1)) begin
                    r_val[i]  = 1'b1;
                    r_addr[i] = 5'($urandom_range(0, 9));
                    r_data[i] = $urandom;
                end
            end
            reserva_valida   = ($urandom_range(0, 2) == 0);
            reserva_endereco = 5'($urandom_range(0, 9));
            EnderecoLeitura1 = 5'($urandom_range(0, 9));
            EnderecoLeitura2 = 5'($urandom_range(0, 31));
            reset            = ($urandom_range(0, 99) == 0);
            ciclo();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_escrita_registradores.md
# controle_escrita_registradores

Write-port controller for the 32×32 register file (`BancoDeRegistradores`). It shares the file's single write port between several writeback sources using round-robin arbitration with a valid/ready handshake, and drives `EscreveRegistrador`, `EnderecoEscrita` and `DadoParaEscrita` from a registered stage. It also keeps a pending-write scoreboard, so issue logic can stall on RAW hazards and refuse WAW reservations. It sits between the execution units (ALU, load unit, multi-cycle multiplier) and the register file.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters (2..8).
- `LARGURA`, default 32: data width; must match the register file.
- `clk`  in  1  the single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valida`  in  NUM_REQ  per-requester write request.
- `req_pronta`  out  NUM_REQ  one-hot grant; combinational from `req_valida` and the pointer.
- `req_endereco`  in  NUM_REQ*5  packed destination addresses; requester i uses bits [5i+4:5i].
- `req_dado`  in  NUM_REQ*LARGURA  packed write data.
- `reserva_valida`  in  1  issue logic reserves a destination register.
- `reserva_endereco`  in  5  register being reserved.
- `reserva_pronta`  out  1  the register in `reserva_endereco` is not busy, so a reservation is legal.
- `EnderecoLeitura1`, `EnderecoLeitura2`  in  5 each  operands to check for hazards.
- `pendente1`, `pendente2`  out  1 each  the operand has a write outstanding.
- `EscreveRegistrador`  out  1  write enable to the register file.
- `EnderecoEscrita`  out  5  write address.
- `DadoParaEscrita`  out  LARGURA  write data.

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1).
  - The grant goes to the first i with `req_valida[i]=1`, searching from `ptr` upward with wrap.
  - `req_pronta` is zero when no requester is valid.
- A transfer happens when `req_valida[i] && req_pronta[i]`.
  - On a transfer, `ptr` becomes (i+1) mod NUM_REQ. Otherwise `ptr` holds.
- Output stage: the edge that accepts a transfer loads address and data into the output registers.
  - `EscreveRegistrador` is 1 for that following cycle only, unless the address is 0.
  - For address 0 the transfer is consumed and `EscreveRegistrador` stays 0.
  - With no transfer, `EscreveRegistrador`=0 and address and data hold their last values.
- Requester rules: once valid is asserted, address and data stay stable and valid stays high until accepted.
- Scoreboard `ocupado[31:0]`, bit 0 hard-wired to 0:
  - Set: `reserva_valida && reserva_pronta && reserva_endereco!=0` sets `ocupado[reserva_endereco]`.
  - Ignored: `reserva_valida` while `reserva_pronta=0`.
  - Clear: `ocupado[EnderecoEscrita]` clears at the edge that ends a cycle with `EscreveRegistrador=1`. This is the same edge at which the register file commits the data.
  - Same-address set and clear on one edge: set wins, and the bit stays 1.
  - A write to a register that is not busy is performed and leaves the scoreboard unchanged.
- `reserva_pronta = ~ocupado[reserva_endereco]`; always 1 for address 0.
- `pendenteN = ocupado[EnderecoLeituraN]`; always 0 for address 0.
  - There is no bypass. The bit stays 1 during the cycle `EscreveRegistrador=1`, so the consumer reads the file the cycle after.
- Reset values: `ptr`=0, `ocupado`=0, `EscreveRegistrador`=0, `EnderecoEscrita`=0, `DadoParaEscrita`=0.
  - Reset mid-operation drops the in-flight write (enable 0 next cycle) and all reservations.
  - `req_pronta` is forced to 0 while `reset` is high.

## Timing
- Latency: 1 cycle from an accepted request to `EscreveRegistrador`=1. The result is visible in the register file from the cycle after that.
- Throughput: 1 write per cycle across all requesters.
- Fairness: with all requesters valid, grants rotate 0,1,2,0,…; any valid requester waits at most NUM_REQ-1 transfers.
- `req_pronta`, `reserva_pronta` and `pendenteN` are combinational; all other outputs are registered.
- Back-to-back writes to the same address in consecutive cycles are legal. The later one wins in the file.

## Structure
- Shared package `pacote_rv`:
  - `NUM_REGS`=32, `ADDR_W`=5, `DATA_W`=32.
  - Requester indices `REQ_ULA`=0, `REQ_MEM`=1, `REQ_MUL`=2.
- Sub-module `arbitro_round_robin`, parameterized by NUM_REQ:
  - Inputs: `clk`, `reset`, request vector, `aceita`.
  - Output: one-hot grant.
  - Owns `ptr`.
- Scoreboard and output stage live in the top module.

## Test plan
- Reset, then idle: all outputs 0, `req_pronta`=0, `reserva_pronta`=1.
- Single write: REQ_ULA sends addr 5, data 0xDEADBEEF → grant the same cycle; next cycle `EscreveRegistrador`=1, addr 5, data 0xDEADBEEF; the cycle after, enable is 0.
- Round-robin: all three requesters continuously valid (addrs 1,2,3) → grants 0,1,2,0,1,2 and one write per cycle.
- Hazard, part 1: reserve x7, then `EnderecoLeitura1`=7 → `pendente1`=1 and `reserva_pronta`=0 for x7.
- Hazard, part 2: REQ_MEM writes x7; `pendente1` stays 1 through the write cycle and falls to 0 the cycle after.
- Boundaries:
  - A request to x0 is accepted with no write enable.
  - A reservation of x0 is ignored.
  - Reserving x9 on the same edge as the write to x9 leaves `ocupado[9]`=1.
  - Asserting `reset` the cycle after acceptance forces enable to 0 and clears the scoreboard.
